// File: rtl/scan_scheduler_pkg.sv
// Shared types and defaults for the dual-scanner ping-pong capture controller.
//   cap_state_e  : capture sequencer states (which buffer is currently filling)
//   xfer_state_e : CPU transfer arbiter states (which buffer is draining)
//   Def*         : default parameter values for scan_scheduler
package scan_scheduler_pkg;

  localparam int unsigned DefAddrW     = 4;
  localparam int unsigned DefFlushSelf = 9;
  localparam int unsigned DefFlushPeer = 4;

  // CapStopping is kept in the encoding so software-visible state maps stay
  // stable; the sequencer reaches IDLE directly on the final buffer-full.
  typedef enum logic [1:0] {
    CapIdle,
    CapScan1,
    CapScan2,
    CapStopping
  } cap_state_e;

  typedef enum logic [1:0] {
    XferIdle,
    XferBuf1,
    XferBuf2
  } xfer_state_e;

endpackage

// File: rtl/scan_xfer_arb.sv
// Transfer arbiter for the single CPU drain path shared by two scanner buffers.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   set1, set2             : one-cycle "buffer filled" events from the capture sequencer
//   cpu_ack                : CPU can accept a drain this cycle
//   addr1, addr2           : scanner buffer addresses (drain progress)
//   transfer1, transfer2   : registered drain enables
//   transfer1_next/2_next  : next-cycle drain enables (used to mask flush)
//   xfer_sel               : 0 = buffer 1 on the CPU path, 1 = buffer 2
//   overrun                : sticky, a buffer refilled before it was drained
module scan_xfer_arb
  import scan_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set1,
  input  logic              set2,
  input  logic              cpu_ack,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic              transfer1,
  output logic              transfer2,
  output logic              transfer1_next,
  output logic              transfer2_next,
  output logic              xfer_sel,
  output logic              overrun
);

  xfer_state_e xstate_q, xstate_d;
  logic pend1_q, pend1_d, pend2_q, pend2_d;
  logic moved1_q, moved1_d, moved2_q, moved2_d;
  // Encoded like xfer_sel (1 = buffer 2); reset to 1 so buffer 1 wins the first tie.
  logic last_grant_q, last_grant_d;
  logic xfer_sel_q, xfer_sel_d;
  logic overrun_q, overrun_d;
  logic eff1, eff2, grant1, grant2;

  // A fill event arriving in the grant cycle is visible to the arbiter so the
  // drain can start without waiting for the pending flag to register.
  assign eff1 = pend1_q | set1;
  assign eff2 = pend2_q | set2;

  always_comb begin
    grant1 = 1'b0;
    grant2 = 1'b0;
    if (xstate_q == XferIdle && cpu_ack) begin
      if (eff1 && eff2) begin
        if (last_grant_q) grant1 = 1'b1;
        else              grant2 = 1'b1;
      end else if (eff1) begin
        grant1 = 1'b1;
      end else if (eff2) begin
        grant2 = 1'b1;
      end
    end
  end

  always_comb begin
    xstate_d     = xstate_q;
    moved1_d     = moved1_q;
    moved2_d     = moved2_q;
    last_grant_d = last_grant_q;
    xfer_sel_d   = xfer_sel_q;
    // A grant consumes the older pending fill; a simultaneous new fill survives.
    pend1_d      = grant1 ? (pend1_q & set1) : (pend1_q | set1);
    pend2_d      = grant2 ? (pend2_q & set2) : (pend2_q | set2);
    overrun_d    = overrun_q | (set1 & pend1_q) | (set2 & pend2_q);

    unique case (xstate_q)
      XferIdle: begin
        if (grant1) begin
          xstate_d     = XferBuf1;
          last_grant_d = 1'b0;
          xfer_sel_d   = 1'b0;
        end else if (grant2) begin
          xstate_d     = XferBuf2;
          last_grant_d = 1'b1;
          xfer_sel_d   = 1'b1;
        end
      end
      XferBuf1: begin
        // Address returns to 0 after wrapping; only count it once it has moved.
        if (addr1 != '0) begin
          moved1_d = 1'b1;
        end else if (moved1_q) begin
          moved1_d = 1'b0;
          xstate_d = XferIdle;
        end
      end
      XferBuf2: begin
        if (addr2 != '0) begin
          moved2_d = 1'b1;
        end else if (moved2_q) begin
          moved2_d = 1'b0;
          xstate_d = XferIdle;
        end
      end
      default: xstate_d = XferIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xstate_q     <= XferIdle;
      pend1_q      <= 1'b0;
      pend2_q      <= 1'b0;
      moved1_q     <= 1'b0;
      moved2_q     <= 1'b0;
      last_grant_q <= 1'b1;
      xfer_sel_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      xstate_q     <= xstate_d;
      pend1_q      <= pend1_d;
      pend2_q      <= pend2_d;
      moved1_q     <= moved1_d;
      moved2_q     <= moved2_d;
      last_grant_q <= last_grant_d;
      xfer_sel_q   <= xfer_sel_d;
      overrun_q    <= overrun_d;
    end
  end

  assign transfer1      = (xstate_q == XferBuf1);
  assign transfer2      = (xstate_q == XferBuf2);
  assign transfer1_next = (xstate_d == XferBuf1);
  assign transfer2_next = (xstate_d == XferBuf2);
  assign xfer_sel       = xfer_sel_q;
  assign overrun        = overrun_q;

endmodule

// File: rtl/scan_scheduler.sv
// Ping-pong capture controller for two scanner buffers: sequences which buffer
// fills, arbitrates the CPU drain path and raises flush requests from fill levels.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   start_req, stop_req    : CPU capture start / stop-after-current-buffer requests
//   cpu_ack                : CPU can accept a buffer drain this cycle
//   ready1, ready2         : scanner buffer full (level)
//   addr1, addr2           : scanner current buffer address
//   start1, start2         : one-cycle start pulses to the scanners
//   transfer1, transfer2   : drain enables to the scanners
//   flush1, flush2         : flush requests (registered)
//   xfer_sel               : buffer on the CPU path (0 = 1, 1 = 2)
//   busy                   : capture sequence active
//   overrun                : sticky buffer-overrun flag
module scan_scheduler
  import scan_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned FLUSH_SELF = DefFlushSelf,
  parameter int unsigned FLUSH_PEER = DefFlushPeer
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_req,
  input  logic              stop_req,
  input  logic              cpu_ack,
  input  logic              ready1,
  input  logic              ready2,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic              start1,
  output logic              start2,
  output logic              transfer1,
  output logic              transfer2,
  output logic              flush1,
  output logic              flush2,
  output logic              xfer_sel,
  output logic              busy,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] SelfThr = ADDR_W'(FLUSH_SELF);
  localparam logic [ADDR_W-1:0] PeerThr = ADDR_W'(FLUSH_PEER);

  cap_state_e cap_q, cap_d;
  logic stop_pend_q, stop_pend_d;
  logic start1_q, start1_d, start2_q, start2_d;
  logic ready1_q, ready2_q;
  logic flush1_q, flush2_q;
  logic rise1, rise2, stop_seen;
  logic set1, set2;
  logic transfer1_next, transfer2_next;

  assign rise1     = ready1 & ~ready1_q;
  assign rise2     = ready2 & ~ready2_q;
  // A stop arriving in the same cycle as the buffer-full still ends capture.
  assign stop_seen = stop_pend_q | stop_req;

  always_comb begin
    cap_d       = cap_q;
    stop_pend_d = stop_pend_q;
    start1_d    = 1'b0;
    start2_d    = 1'b0;
    set1        = 1'b0;
    set2        = 1'b0;
    unique case (cap_q)
      CapIdle: begin
        stop_pend_d = 1'b0;
        if (start_req) begin
          cap_d    = CapScan1;
          start1_d = 1'b1;
        end
      end
      CapScan1: begin
        if (stop_req) stop_pend_d = 1'b1;
        if (rise1) begin
          set1 = 1'b1;
          if (stop_seen) begin
            cap_d       = CapIdle;
            stop_pend_d = 1'b0;
          end else begin
            cap_d    = CapScan2;
            start2_d = 1'b1;
          end
        end
      end
      CapScan2: begin
        if (stop_req) stop_pend_d = 1'b1;
        if (rise2) begin
          set2 = 1'b1;
          if (stop_seen) begin
            cap_d       = CapIdle;
            stop_pend_d = 1'b0;
          end else begin
            cap_d    = CapScan1;
            start1_d = 1'b1;
          end
        end
      end
      default: begin
        cap_d       = CapIdle;
        stop_pend_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q       <= CapIdle;
      stop_pend_q <= 1'b0;
      start1_q    <= 1'b0;
      start2_q    <= 1'b0;
      ready1_q    <= 1'b0;
      ready2_q    <= 1'b0;
      flush1_q    <= 1'b0;
      flush2_q    <= 1'b0;
    end else begin
      cap_q       <= cap_d;
      stop_pend_q <= stop_pend_d;
      start1_q    <= start1_d;
      start2_q    <= start2_d;
      ready1_q    <= ready1;
      ready2_q    <= ready2;
      // Masked with the next-cycle drain enable so flush and transfer on the
      // same buffer are never high together, including the grant cycle.
      flush1_q    <= (addr1 >= SelfThr) && (addr2 >= PeerThr) && !transfer1_next;
      flush2_q    <= (addr2 >= SelfThr) && (addr1 >= PeerThr) && !transfer2_next;
    end
  end

  scan_xfer_arb #(
    .ADDR_W(ADDR_W)
  ) u_arb (
    .clk            (clk),
    .rst            (rst),
    .set1           (set1),
    .set2           (set2),
    .cpu_ack        (cpu_ack),
    .addr1          (addr1),
    .addr2          (addr2),
    .transfer1      (transfer1),
    .transfer2      (transfer2),
    .transfer1_next (transfer1_next),
    .transfer2_next (transfer2_next),
    .xfer_sel       (xfer_sel),
    .overrun        (overrun)
  );

  assign start1 = start1_q;
  assign start2 = start2_q;
  assign flush1 = flush1_q;
  assign flush2 = flush2_q;
  assign busy   = (cap_q != CapIdle);

endmodule

// File: tb/tb_scan_scheduler.sv
module tb_scan_scheduler;

  logic       clk = 1'b0;
  logic       rst, start_req, stop_req, cpu_ack, ready1, ready2;
  logic [3:0] addr1, addr2;
  logic       start1, start2, transfer1, transfer2, flush1, flush2, xfer_sel, busy, overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_scheduler #(
    .ADDR_W     (4),
    .FLUSH_SELF (9),
    .FLUSH_PEER (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_req (start_req),
    .stop_req  (stop_req),
    .cpu_ack   (cpu_ack),
    .ready1    (ready1),
    .ready2    (ready2),
    .addr1     (addr1),
    .addr2     (addr2),
    .start1    (start1),
    .start2    (start2),
    .transfer1 (transfer1),
    .transfer2 (transfer2),
    .flush1    (flush1),
    .flush2    (flush2),
    .xfer_sel  (xfer_sel),
    .busy      (busy),
    .overrun   (overrun)
  );

  // exp = {start1, start2, transfer1, transfer2, flush1, flush2, xfer_sel, busy, overrun}
  typedef struct packed {
    logic       rst;
    logic       start_req;
    logic       stop_req;
    logic       cpu_ack;
    logic       ready1;
    logic       ready2;
    logic [3:0] addr1;
    logic [3:0] addr2;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic r, input logic s, input logic p, input logic a,
                               input logic r1, input logic r2, input logic [3:0] a1,
                               input logic [3:0] a2, input logic [8:0] e);
    vec_t v;
    v.rst = r; v.start_req = s; v.stop_req = p; v.cpu_ack = a;
    v.ready1 = r1; v.ready2 = r2; v.addr1 = a1; v.addr2 = a2; v.exp = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [8:0] outs();
    return {start1, start2, transfer1, transfer2, flush1, flush2, xfer_sel, busy, overrun};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_req = 1'b0; stop_req = 1'b0; cpu_ack = 1'b0;
    ready1 = 1'b0; ready2 = 1'b0; addr1 = '0; addr2 = '0;

    //            rst st sp ak r1 r2 a1  a2   s1 s2 t1 t2 f1 f2 sl by ov
    vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 0,  0,  9'b0_0_0_0_0_0_0_0_0)); // reset
    vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 0,  0,  9'b1_0_0_0_0_0_0_1_0)); // start1 pulse
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  0,  9'b0_0_0_0_0_0_0_1_0));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 0,  0,  9'b0_0_0_0_0_0_0_1_0)); // start ignored
    vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 0,  0,  9'b0_1_1_0_0_0_0_1_0)); // fill1 + grant1
    vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 1,  0,  9'b0_0_1_0_0_0_0_1_0));
    vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 15, 4,  9'b0_0_1_0_0_0_0_1_0)); // no flush while drain
    vecs.push_back(mkv(0, 0, 0, 1, 0, 0, 0,  4,  9'b0_0_0_0_0_0_0_1_0)); // drain done
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 9,  4,  9'b0_0_0_0_1_0_0_1_0)); // flush1 at threshold
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 8,  4,  9'b0_0_0_0_0_0_0_1_0)); // just below
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 0,  0,  9'b1_0_0_0_0_0_0_1_0)); // fill2 -> start1
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  0,  9'b0_0_0_0_0_0_0_1_0));
    vecs.push_back(mkv(0, 0, 0, 0, 1, 0, 0,  0,  9'b0_1_0_0_0_0_0_1_0)); // both pending
    vecs.push_back(mkv(0, 0, 0, 1, 0, 0, 0,  0,  9'b0_0_0_1_0_0_1_1_0)); // tie -> buffer 2
    vecs.push_back(mkv(0, 0, 0, 1, 0, 0, 5,  12, 9'b0_0_0_1_0_0_1_1_0)); // no flush2 while drain
    vecs.push_back(mkv(0, 0, 0, 1, 0, 0, 0,  0,  9'b0_0_0_0_0_0_1_1_0)); // idle gap
    vecs.push_back(mkv(0, 0, 0, 1, 0, 0, 0,  0,  9'b0_0_1_0_0_0_0_1_0)); // then buffer 1
    vecs.push_back(mkv(0, 0, 0, 1, 0, 0, 3,  0,  9'b0_0_1_0_0_0_0_1_0));
    vecs.push_back(mkv(0, 0, 0, 1, 0, 1, 3,  0,  9'b1_0_1_0_0_0_0_1_0));
    vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 3,  0,  9'b0_1_1_0_0_0_0_1_0));
    vecs.push_back(mkv(0, 0, 0, 1, 0, 1, 3,  0,  9'b1_0_1_0_0_0_0_1_1)); // refill2 -> overrun
    vecs.push_back(mkv(0, 0, 0, 1, 1, 0, 3,  0,  9'b0_1_1_0_0_0_0_1_1));
    vecs.push_back(mkv(0, 0, 1, 1, 0, 0, 3,  0,  9'b0_0_1_0_0_0_0_1_1)); // stop in SCAN2
    vecs.push_back(mkv(0, 0, 0, 1, 0, 1, 3,  0,  9'b0_0_1_0_0_0_0_0_1)); // no start1, idle
    vecs.push_back(mkv(0, 0, 0, 1, 0, 0, 3,  0,  9'b0_0_1_0_0_0_0_0_1));
    vecs.push_back(mkv(1, 0, 0, 1, 0, 0, 3,  0,  9'b0_0_0_0_0_0_0_0_0)); // reset mid-drain
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0,  0,  9'b0_0_0_0_0_0_0_0_0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst; start_req = vecs[i].start_req; stop_req = vecs[i].stop_req;
      cpu_ack = vecs[i].cpu_ack; ready1 = vecs[i].ready1; ready2 = vecs[i].ready2;
      addr1 = vecs[i].addr1; addr2 = vecs[i].addr2;
      tick();
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Full drain of buffer 1 with address wrap back to 0.
    start_req = 1'b1; tick(); start_req = 1'b0;
    check("seq_start1", 32'(start1), 32'd1);
    ready1 = 1'b1; cpu_ack = 1'b1; tick();
    check("seq_grant1", 32'({transfer1, xfer_sel}), 32'b10);
    for (int a = 1; a < 16; a++) begin
      addr1 = 4'(a); tick();
      check($sformatf("seq_drain_a%0d", a), 32'(transfer1), 32'd1);
    end
    addr1 = '0; tick();
    check("seq_drain_end", 32'(transfer1), 32'd0);
    ready1 = 1'b0; cpu_ack = 1'b0;

    // Buffer 1 fills twice with no CPU ack -> sticky overrun until reset.
    rst = 1'b1; tick(); rst = 1'b0;
    start_req = 1'b1; tick(); start_req = 1'b0;
    ready1 = 1'b1; tick(); ready1 = 1'b0; tick();
    ready2 = 1'b1; tick(); ready2 = 1'b0; tick();
    check("ovr_before", 32'(overrun), 32'd0);
    ready1 = 1'b1; tick(); ready1 = 1'b0;
    check("ovr_set", 32'(overrun), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("ovr_sticky%0d", k), 32'(overrun), 32'd1);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    check("ovr_clear", 32'(overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
